// File: rtl/pwm_tone_generator.sv
// Note player: accepts (half-period, duration, volume) commands and drives a PWM-chopped square wave, then a silent gap.
// Build option TONE_ABORT_EN adds an abort input that cancels the current note (no done pulse).
module pwm_tone_generator #(
  parameter int PERIOD_W  = 20,
  parameter int DUR_W     = 16,
  parameter int VOL_W     = 4,
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic [DUR_W-1:0]    note_duration,
  input  logic [VOL_W-1:0]    note_volume,
`ifdef TONE_ABORT_EN
  input  logic                abort,
`endif
  output logic                audio_signal,
  output logic                busy,
  output logic                done
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam int REM_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [REM_W-1:0]  GAP_LOAD  = REM_W'(GAP_TICKS);
  localparam logic [REM_W-1:0]  REM_ONE   = REM_W'(1);
  localparam bit                HAS_GAP   = (GAP_TICKS > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [PERIOD_W-1:0] period_q;
  logic [VOL_W-1:0]    volume_q;
  logic [PERIOD_W-1:0] half_cnt;
  logic [VOL_W-1:0]    pwm_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  // Remaining ticks: note duration while playing, reloaded with the gap length on exit.
  logic [REM_W-1:0]    dur_rem;
  logic                phase;

  logic                accept;
  logic                abort_req;
  logic                tick;
  logic                last_tick;
  logic                half_last;
  logic                finish;
  logic [PERIOD_W-1:0] period_m1;

  assign accept    = note_valid && note_ready;
  assign tick      = (tick_cnt == TICK_LAST);
  assign last_tick = tick && (dur_rem == REM_ONE);
  assign period_m1 = period_q - PERIOD_W'(1);
  assign half_last = (half_cnt == period_m1);

`ifdef TONE_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // A natural end of note: last gap tick, or last play tick when there is no gap.
  assign finish = !abort_req && last_tick &&
                  ((state == GAP) || ((state == PLAY) && !HAS_GAP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && (note_duration != '0)) begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (abort_req) begin
          state_next = IDLE;
        end else if (last_tick) begin
          state_next = HAS_GAP ? GAP : IDLE;
        end
      end
      GAP: begin
        if (abort_req || last_tick) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    note_ready = (state == IDLE);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      volume_q <= '0;
    end else if (accept) begin
      period_q <= note_period;
      volume_q <= note_volume;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt <= '0;
      pwm_cnt  <= '0;
      tick_cnt <= '0;
      dur_rem  <= '0;
      phase    <= 1'b0;
    end else if (accept) begin
      half_cnt <= '0;
      pwm_cnt  <= '0;
      tick_cnt <= '0;
      dur_rem  <= REM_W'(note_duration);
      phase    <= 1'b1;
    end else if (abort_req) begin
      half_cnt <= '0;
      pwm_cnt  <= '0;
      tick_cnt <= '0;
      dur_rem  <= '0;
      phase    <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
          if (last_tick) begin
            half_cnt <= '0;
            pwm_cnt  <= '0;
            phase    <= 1'b0;
            dur_rem  <= HAS_GAP ? GAP_LOAD : '0;
          end else begin
            pwm_cnt <= pwm_cnt + VOL_W'(1);
            if (half_last) begin
              half_cnt <= '0;
              phase    <= ~phase;
            end else begin
              half_cnt <= half_cnt + PERIOD_W'(1);
            end
            if (tick) begin
              dur_rem <= dur_rem - REM_ONE;
            end
          end
        end
        GAP: begin
          tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
          if (tick) begin
            dur_rem <= dur_rem - REM_ONE;
          end
        end
        default: begin
          half_cnt <= half_cnt;
          pwm_cnt  <= pwm_cnt;
          tick_cnt <= tick_cnt;
          dur_rem  <= dur_rem;
          phase    <= phase;
        end
      endcase
    end
  end

  // Audio is low everywhere except PLAY cycles that are not the exit or abort edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_signal <= 1'b0;
    end else if ((state == PLAY) && !abort_req && !last_tick) begin
      audio_signal <= phase && (period_q != '0) && (pwm_cnt < volume_q);
    end else begin
      audio_signal <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= finish || (accept && (note_duration == '0));
    end
  end

endmodule
